div_exec_unit: RTL and testbench
================================

Name: div_exec_unit

Overview:
- Multi-cycle integer divide unit in the EX stage. It consumes the 5-bit ALU control code and operands produced by decode.
- When the control code selects DIV or DIVU, it runs a radix-2 restoring division, one quotient bit per cycle.
- While busy it stalls the pipeline. On completion it delivers {HI=remainder, LO=quotient} to the HI/LO write path.

Parameters:
- DIV_CODE, default `SIG_ALU_DIV, alucontrol value selecting signed divide
- DIVU_CODE, default `SIG_ALU_DIVU, alucontrol value selecting unsigned divide
- WIDTH, default 32, operand width; the iteration count equals WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- alucontrolE  in  5  ALU control code of the instruction in EX
- validE  in  1  EX holds a valid, non-bubble instruction
- flushE  in  1  EX flush (exception or branch squash); aborts any division in progress
- srcaE  in  WIDTH  dividend
- srcbE  in  WIDTH  divisor
- stall_div  out  1  pipeline stall request while a division is pending
- div_ready  out  1  one-cycle pulse: result valid this cycle
- div_result  out  2*WIDTH  {remainder, quotient}; bits [63:32] are HI, bits [31:0] are LO

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; div_result=0; div_ready=0; iteration counter=0. Internal operand and sign registers are cleared. stall_div=0 on the cycle after reset.
- start = validE & ~flushE & (alucontrolE==DIV_CODE | alucontrolE==DIVU_CODE).
- States and transitions:
  - IDLE: when start=1, latch the operands and go to RUN. The signed flag is set only for DIV_CODE. |srcaE| and |srcbE| are latched for a signed divide; raw values for unsigned. The signs sa=srcaE[31] and sb=srcbE[31] are latched; both are forced to 0 for unsigned.
  - Divisor zero at start: go to DONE directly, skipping RUN.
  - RUN: one restoring step per cycle, MSB first.
    - Shift {rem, dividend} left by 1.
    - If rem >= divisor: rem -= divisor and the quotient bit is 1.
    - The counter counts 0..WIDTH-1. After the step with counter=WIDTH-1, go to DONE.
  - DONE: div_result is registered.
    - Quotient is negated if sa^sb.
    - Remainder is negated if sa.
    - div_ready=1 for exactly this cycle.
    - Next state is IDLE, or RUN if start=1 in this cycle. A back-to-back divide is accepted.
- stall_div is combinational: (state==IDLE & start) | state==RUN | (state==DONE & start). It is 0 in the DONE cycle unless a new start occurs.
- Latency: start in cycle T, RUN in T+1..T+WIDTH, DONE/div_ready in T+WIDTH+1. stall_div is high in cycles T..T+WIDTH (33 cycles for WIDTH=32).
- Divide by zero: DONE in T+1. quotient=all ones, remainder=dividend (raw srcaE). No sign correction. stall_div is high only in cycle T.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. This is the natural result of magnitude division plus negation; no special case.
- flushE=1 in RUN or DONE: next state is IDLE. div_ready is not asserted (forced 0 in a flushed DONE cycle). div_result keeps its previous value. stall_div drops combinationally in the flush cycle.
- Operand changes on srcaE/srcbE during RUN are ignored, because the values are latched at start.
- Non-divide codes: no state change. div_result holds its last value indefinitely.
- Reset mid-RUN has priority over all inputs: returns to IDLE with outputs cleared.

Test Plan:
- DIVU, srcaE=100, srcbE=7, validE=1 for 1 cycle -> stall_div high 33 cycles; div_ready at T+33; div_result={0x00000002, 0x0000000E}.
- DIV, srcaE=0xFFFFFF9C (-100), srcbE=7 -> div_result={0xFFFFFFFE, 0xFFFFFFF2} (rem -2, quo -14); DIV -2^31 / -1 -> {0x00000000, 0x80000000}.
- DIVU, srcaE=0x12345678, srcbE=0 -> stall_div only in cycle T; div_ready at T+1; div_result={0x12345678, 0xFFFFFFFF}.
- Start DIVU 100/7, assert flushE at T+10 -> stall_div=0 at T+10; no div_ready pulse; div_result keeps its prior value; a new DIVU 9/2 at T+12 -> {1, 4} at T+45.
- Back-to-back: second DIV start asserted in the DONE cycle of the first -> first result presented with div_ready; stall_div stays high; second result 32+1 cycles later.
- rst asserted at T+5 of a division -> IDLE; div_result=0; div_ready=0; stall_div=0 next cycle; ANDI/OR codes with validE=1 never raise stall_div.

Source files
------------

// File: rtl/div_exec_unit.sv
// Radix-2 restoring divider for the EX stage: one quotient bit per cycle, {HI=rem, LO=quo} on completion.
// Latency WIDTH+1 cycles from start (1 for a zero divisor); stall_div holds the pipeline while busy.
`ifndef SIG_ALU_DIV
`define SIG_ALU_DIV 5'b11010
`endif
`ifndef SIG_ALU_DIVU
`define SIG_ALU_DIVU 5'b11011
`endif

module div_exec_unit #(
    parameter logic [4:0] DIV_CODE  = `SIG_ALU_DIV,
    parameter logic [4:0] DIVU_CODE = `SIG_ALU_DIVU,
    parameter int         WIDTH     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         alucontrolE,
    input  logic               validE,
    input  logic               flushE,
    input  logic [WIDTH-1:0]   srcaE,
    input  logic [WIDTH-1:0]   srcbE,
    output logic               stall_div,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic             start, is_signed, a_neg, b_neg, q_bit;
    logic [WIDTH-1:0] a_mag, b_mag, rem_nx, dvd_nx, quo_fix, rem_fix;
    logic [WIDTH:0]   rem_sh, sub;

    always_comb begin
        start     = validE & ~flushE & ((alucontrolE == DIV_CODE) | (alucontrolE == DIVU_CODE));
        is_signed = (alucontrolE == DIV_CODE);
        a_neg     = is_signed & srcaE[WIDTH-1];
        b_neg     = is_signed & srcbE[WIDTH-1];
        a_mag     = a_neg ? -srcaE : srcaE;
        b_mag     = b_neg ? -srcbE : srcbE;

        // Borrow out of the trial subtraction decides the quotient bit.
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        sub     = rem_sh - {1'b0, dvs_q};
        q_bit   = ~sub[WIDTH];
        rem_nx  = q_bit ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx  = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix = (sa_q ^ sb_q) ? -dvd_nx : dvd_nx;
        rem_fix = sa_q ? -rem_nx : rem_nx;

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        pend_d   = pend_q;
        result_d = result_q;

        case (state_q)
            S_RUN: begin
                if (flushE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        pend_d  = {rem_fix, quo_fix};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flushE)
                    result_d = pend_q;
            end
            default: ;
        endcase

        // A new divide may launch from IDLE or from the DONE cycle of the previous one.
        if (start && state_q != S_RUN) begin
            if (srcbE == '0) begin
                state_d = S_DONE;
                pend_d  = {srcaE, {WIDTH{1'b1}}};
            end else begin
                state_d = S_RUN;
                cnt_d   = '0;
                rem_d   = '0;
                dvd_d   = a_mag;
                dvs_d   = b_mag;
                sa_d    = a_neg;
                sb_d    = b_neg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            pend_q   <= pend_d;
            result_q <= result_d;
        end
    end

    // A flush in the DONE cycle suppresses the pulse and leaves the old result visible.
    assign div_ready  = (state_q == S_DONE) & ~flushE;
    assign div_result = div_ready ? pend_q : result_q;
    assign stall_div  = (start & (state_q != S_RUN)) | ((state_q == S_RUN) & ~flushE);

endmodule

// File: tb/tb_div_exec_unit.sv
// Scoreboard bench for div_exec_unit: expected results queued at launch, compared on div_ready.
module tb_div_exec_unit;
    localparam int         W      = 32;
    localparam logic [4:0] C_DIV  = 5'b11010;
    localparam logic [4:0] C_DIVU = 5'b11011;
    localparam logic [4:0] C_ANDI = 5'b00100;
    localparam logic [4:0] C_OR   = 5'b00101;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    alucontrolE;
    logic          validE, flushE;
    logic [W-1:0]  srcaE, srcbE;
    logic          stall_div, div_ready;
    logic [2*W-1:0] div_result;

    int n_checks = 0;
    int n_errors = 0;
    int n_ready  = 0;
    int n_pushed = 0;
    int cyc      = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;

    div_exec_unit #(.DIV_CODE(C_DIV), .DIVU_CODE(C_DIVU), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .alucontrolE(alucontrolE), .validE(validE), .flushE(flushE),
        .srcaE(srcaE), .srcbE(srcbE), .stall_div(stall_div), .div_ready(div_ready),
        .div_result(div_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && div_ready) begin
            n_ready++;
            if (exp_q.size() == 0)
                check("unexpected_ready", {63'd0, div_ready}, 64'd0);
            else
                check("div_result", div_result, exp_q.pop_front());
        end
    end

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int signed q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    task automatic start_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        alucontrolE = code; srcaE = a; srcbE = b; validE = 1'b1;
    endtask

    task automatic end_op();
        @(posedge clk); #1;
        validE = 1'b0; alucontrolE = C_OR; srcaE = $urandom; srcbE = $urandom;
    endtask

    task automatic push_exp(input logic [63:0] v);
        exp_q.push_back(v);
        n_pushed++;
    endtask

    task automatic wait_ready(input int t0, input int exp_lat);
        int stalls = 0;
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (div_ready) begin seen = 1; break; end
            if (stall_div) stalls++;
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
        check("latency", 64'(cyc - t0), 64'(exp_lat));
        check("stall_cycles", 64'(stalls), 64'(exp_lat - 1));
    endtask

    task automatic run_one(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv, input int exp_lat);
        int t0;
        start_op(code, a, b);
        push_exp(expv);
        t0 = cyc;
        @(negedge clk);
        check("stall_T", {63'd0, stall_div}, 64'd1);
        end_op();
        wait_ready(t0, exp_lat);
        check("stall_at_ready", {63'd0, stall_div}, 64'd0);
        last_exp = expv;
        @(negedge clk);
        check("ready_pulse", {63'd0, div_ready}, 64'd0);
        check("result_hold", div_result, last_exp);
    endtask

    initial begin
        int t0, t1;
        logic [31:0] a, b;
        logic sg;
        rst = 1'b1; validE = 1'b0; flushE = 1'b0; alucontrolE = C_OR; srcaE = '0; srcbE = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", div_result, 64'd0);
        check("rst_ready", {63'd0, div_ready}, 64'd0);
        check("rst_stall", {63'd0, stall_div}, 64'd0);

        run_one(C_DIVU, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
        run_one(C_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
        run_one(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_one(C_DIVU, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        run_one(C_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);

        // Non-divide codes leave the held result untouched and never stall.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            alucontrolE = (i % 2) ? C_ANDI : C_OR; validE = 1'b1; srcaE = $urandom; srcbE = $urandom;
            @(negedge clk);
            check("nondiv_stall", {63'd0, stall_div}, 64'd0);
            check("nondiv_hold", div_result, last_exp);
        end
        @(posedge clk); #1 validE = 1'b0;

        // Flush mid-run: no pulse, result held, then a fresh divide.
        start_op(C_DIVU, 32'd100, 32'd7);
        t0 = cyc;
        end_op();
        repeat (9) @(posedge clk);
        #1 flushE = 1'b1;
        @(negedge clk);
        check("flush_stall", {63'd0, stall_div}, 64'd0);
        check("flush_ready", {63'd0, div_ready}, 64'd0);
        check("flush_cycle", 64'(cyc - t0), 64'd10);
        @(posedge clk); #1 flushE = 1'b0;
        @(negedge clk);
        check("post_flush_stall", {63'd0, stall_div}, 64'd0);
        check("post_flush_hold", div_result, last_exp);
        run_one(C_DIVU, 32'd9, 32'd2, {32'd1, 32'd4}, 33);

        // Back-to-back: second start lands in the DONE cycle of the first.
        start_op(C_DIV, 32'hFFFF_FF9C, 32'd7);
        push_exp({32'hFFFF_FFFE, 32'hFFFF_FFF2});
        t0 = cyc;
        end_op();
        repeat (32) @(posedge clk);
        #1;
        alucontrolE = C_DIV; srcaE = 32'h8000_0000; srcbE = 32'hFFFF_FFFF; validE = 1'b1;
        push_exp({32'h0, 32'h8000_0000});
        t1 = cyc;
        @(negedge clk);
        check("b2b_first_lat", 64'(t1 - t0), 64'd33);
        check("b2b_ready", {63'd0, div_ready}, 64'd1);
        check("b2b_stall", {63'd0, stall_div}, 64'd1);
        end_op();
        wait_ready(t1, 33);
        last_exp = {32'h0, 32'h8000_0000};

        for (int i = 0; i < 8; i++) begin
            sg = i[0];
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i == 5) b = 32'd0;
            run_one(sg ? C_DIV : C_DIVU, a, b, ref_div(sg, a, b), (b == 0) ? 1 : 33);
        end

        // Reset in the middle of a run.
        start_op(C_DIVU, 32'd1000, 32'd3);
        end_op();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_result", div_result, 64'd0);
        check("midrst_ready", {63'd0, div_ready}, 64'd0);
        check("midrst_stall", {63'd0, stall_div}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            alucontrolE = (i % 2) ? C_ANDI : C_OR; validE = 1'b1; srcaE = $urandom; srcbE = $urandom;
            @(negedge clk);
            if (stall_div || div_ready || div_result != 64'd0)
                check("midrst_idle", {62'd0, stall_div, div_ready} | div_result, 64'd0);
        end
        @(posedge clk); #1 validE = 1'b0;

        repeat (5) @(posedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("ready_count", 64'(n_ready), 64'(n_pushed));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
